// File: rtl/mult_issue_pkg.sv
// rtl/mult_issue_pkg.sv - shared constants for the MULT issue/writeback sequencer
package mult_issue_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0]  RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exception;
  } wb_payload_t;

endpackage

// File: rtl/mult_watchdog.sv
// rtl/mult_watchdog.sv - cycle counter that flags a multiply running too long
module mult_watchdog
  import mult_issue_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clock,
  input  logic clear_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - issues MULT to the Booth multiplier and hands the result to writeback
// Optional RSTATUS_WRITE_EN: faulting multiplies write MULT_EXC_CODE into RSTATUS_REG instead of rd.
module mult_issue_ctrl
  import mult_issue_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        ex_valid,
  input  logic        ex_is_mult,
  input  logic [31:0] ex_operandA,
  input  logic [31:0] ex_operandB,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic [31:0] mult_operandA,
  output logic [31:0] mult_operandB,
  output logic        ctrl_MULT,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic        mult_resultRDY,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  logic [1:0]  state;
  logic [4:0]  rd_q;
  logic        accept;
  logic        in_busy;
  logic        expired;
  logic        finish;
  logic [31:0] cap_data;
  logic        cap_exc;
  wb_payload_t fin;

  assign accept  = (state == ST_IDLE) && ex_valid && ex_is_mult;
  assign in_busy = (state == ST_BUSY);
  // A ready result takes priority over a watchdog expiry in the same cycle.
  assign finish   = in_busy && (mult_resultRDY || expired);
  assign cap_data = mult_resultRDY ? mult_result : 32'd0;
  assign cap_exc  = mult_resultRDY ? mult_exception : 1'b1;

  always_comb begin
    fin.rd        = rd_q;
    fin.data      = cap_data;
    fin.exception = cap_exc;
`ifdef RSTATUS_WRITE_EN
    if (cap_exc) begin
      fin.rd   = RSTATUS_REG;
      fin.data = MULT_EXC_CODE;
    end
`endif
  end

  // Releasing stall in the handshake cycle lets the MULT leave execute as we return to IDLE.
  always_comb begin
    stall = 1'b0;
    if (clear_n) begin
      case (state)
        ST_IDLE:  stall = accept;
        ST_ISSUE: stall = 1'b1;
        ST_BUSY:  stall = 1'b1;
        ST_DONE:  stall = ~wb_ready;
        default:  stall = 1'b0;
      endcase
    end
  end

  mult_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (state == ST_ISSUE),
    .en      (in_busy),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state         <= ST_IDLE;
      rd_q          <= '0;
      mult_operandA <= '0;
      mult_operandB <= '0;
      ctrl_MULT     <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_exception  <= 1'b0;
    end else begin
      ctrl_MULT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mult_operandA <= ex_operandA;
            mult_operandB <= ex_operandB;
            rd_q          <= ex_rd;
            ctrl_MULT     <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (finish) begin
            wb_rd        <= fin.rd;
            wb_data      <= fin.data;
            wb_exception <= fin.exception;
            wb_valid     <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
